booth_divider: RTL
==================

# booth_divider

Sequential signed integer divider, the inverse companion of the Booth multiplier in the arithmetic datapath. It accepts an N-bit signed dividend and divisor on a start pulse and runs an N-iteration restoring shift/subtract loop on magnitudes. It applies C-style sign correction: the quotient truncates toward zero and the remainder takes the dividend's sign. It reports the result with a one-cycle done strobe. The same start/done handshake and the shared carry-lookahead adder serve as the subtract engine.

## Interface
- N, 4: operand width in bits, N ≥ 2.

- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  N  signed; sampled on the edge leaving IDLE
- divisor  in  N  signed; sampled on the edge leaving IDLE
- quotient  out  N  signed; registered, reset 0
- remainder  out  N  signed; registered, reset 0
- done  out  1  high exactly one cycle (DONE state); reset 0
- divide_by_zero  out  1  registered; valid with done, held until next start; reset 0

## Operation
- Registers:
  - A (N+1 b) partial remainder
  - Q (N b) |dividend|, becomes quotient
  - M (N+1 b) |divisor|
  - count ($clog2(N) b)
  - q_neg, r_neg sign flags
- IDLE: on start=1, latch operands and go to INITIALIZE. Otherwise stay.
- INITIALIZE:
  - Q←|dividend| as unsigned N bits, so −2^(N−1) maps to 2^(N−1).
  - M←|divisor|, A←0, count←0.
  - q_neg←sign(dividend)^sign(divisor), r_neg←sign(dividend).
  - If divisor==0: quotient←all ones (−1), remainder←dividend, divide_by_zero←1, go to DONE.
  - Otherwise divide_by_zero←0 and go to SHIFT.
- SHIFT: {A,Q}←{A,Q}<<1. Adder inputs: A=shifted A, B=~M, CIN=1, giving A−M. Go to TEST.
- TEST:
  - If sum[N]==0: A←sum, Q[0]←1.
  - Else: A unchanged (restore), Q[0]←0.
  - count←count+1. If count==N−1 go to SIGN_FIX, else go to SHIFT.
- SIGN_FIX: quotient←q_neg ? −Q : Q, remainder←r_neg ? −A[N−1:0] : A[N−1:0]. Go to DONE.
- DONE: done=1, then go to IDLE.
- Overflow: −2^(N−1) / −1 wraps to quotient −2^(N−1), remainder 0. No flag is raised.
- quotient, remainder and divide_by_zero hold after DONE until the next completed operation.
- start outside IDLE is ignored; there is no queuing.
- Mid-operation reset_n low clears all registers and outputs immediately and sets the state to IDLE. The partial result is discarded.

## Timing
- Edge E0 samples start=1 in IDLE and enters INITIALIZE.
- Normal path:
  - E1 enters SHIFT.
  - SHIFT/TEST alternate, 2N cycles in total.
  - E(2N+1) enters SIGN_FIX.
  - E(2N+2) enters DONE; done is high for the following cycle.
  - For N=4, done is high after the 10th edge counted from E0.
- Divide-by-zero path: E1 enters DONE, so done is high one cycle after INITIALIZE.
- Back-to-back: start held high re-launches on the edge after DONE (DONE→IDLE, then IDLE samples start). Minimum spacing is 2N+4 cycles.
- The adder is combinational. Its result is used in the TEST cycle from operands registered in SHIFT.

## Structure
- Package booth_divider_pkg holds:
  - state enum (IDLE, INITIALIZE, SHIFT, TEST, SIGN_FIX, DONE), 3-bit encoding
  - no N-dependent constants
- Single sub-module: the existing carry_lookahead_adder, instantiated with N=N+1. Ports A=A_shifted, B=~M, CIN=1'b1; the carry out is unused.
- Single always_ff FSM plus continuous assigns for done and adder inputs. Roughly 150–200 lines.

## Test plan
- N=4, 7/2 → quotient 3, remainder 1, divide_by_zero 0. done high after the 10th edge counted from E0.
- −7/2 → −3, −1. 7/−2 → −3, 1. −7/−2 → 3, −1.
- −8/−1 → quotient −8 (wrap), remainder 0. −8/3 → −2, −2. 0/5 → 0, 0.
- 5/0 → divide_by_zero 1, quotient −1 (4'hF), remainder 5. done high one cycle after INITIALIZE.
- reset_n pulsed low during the third TEST → all outputs 0 at once, state IDLE. A new 6/3 then completes → 2, 0.
- start held high for 30 cycles with operands 7/3 → done pulses every 2N+4 cycles, each result 2, 1. Outputs hold between pulses.

Source files
------------

// File: rtl/booth_divider_pkg.sv
// Shared types for the sequential signed divider.
// FSM state encoding only; widths live with the instantiating module.
package booth_divider_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INITIALIZE = 3'd1,
        SHIFT      = 3'd2,
        TEST       = 3'd3,
        SIGN_FIX   = 3'd4,
        DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/carry_lookahead_adder.sv
// Parameterised carry-lookahead adder, shared arithmetic building block.
// Each carry is expanded as a flat generate/propagate product of lower bits.
module carry_lookahead_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN,
    output logic [N-1:0] SUM,
    output logic         COUT
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = A & B;
    assign p = A ^ B;

    always_comb begin : carry_tree
        logic acc;
        c = '0;
        for (int i = 0; i <= N; i++) begin
            acc = CIN;
            for (int j = 0; j < i; j++) begin
                acc = g[j] | (p[j] & acc);
            end
            c[i] = acc;
        end
    end

    assign SUM  = p ^ c[N-1:0];
    assign COUT = c[N];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring shift/subtract on magnitudes,
// C-style sign correction (truncate toward zero, remainder follows dividend).
module booth_divider
    import booth_divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         done,
    output logic         divide_by_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  dvd_r;
    logic [N-1:0]  dvs_r;
    logic [N:0]    a_reg;
    logic [N-1:0]  q_reg;
    logic [N:0]    m_reg;
    logic [CW-1:0] count;
    logic          q_neg;
    logic          r_neg;

    logic [N-1:0]  abs_dvd;
    logic [N-1:0]  abs_dvs;
    logic [N:0]    a_shifted;
    logic [N:0]    m_inv;
    logic [N:0]    sum;
    logic          unused_cout;

    // Magnitudes are unsigned, so the most negative value maps cleanly.
    assign abs_dvd   = dvd_r[N-1] ? -dvd_r : dvd_r;
    assign abs_dvs   = dvs_r[N-1] ? -dvs_r : dvs_r;
    assign a_shifted = a_reg;
    assign m_inv     = ~m_reg;
    assign done      = (state == DONE);

    carry_lookahead_adder #(
        .N(N + 1)
    ) u_sub (
        .A   (a_shifted),
        .B   (m_inv),
        .CIN (1'b1),
        .SUM (sum),
        .COUT(unused_cout)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:       if (start) state_nx = INITIALIZE;
            INITIALIZE: state_nx = (dvs_r == '0) ? DONE : SHIFT;
            SHIFT:      state_nx = TEST;
            TEST:       state_nx = (count == LAST) ? SIGN_FIX : SHIFT;
            SIGN_FIX:   state_nx = DONE;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            dvd_r          <= '0;
            dvs_r          <= '0;
            a_reg          <= '0;
            q_reg          <= '0;
            m_reg          <= '0;
            count          <= '0;
            q_neg          <= 1'b0;
            r_neg          <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            divide_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r <= dividend;
                        dvs_r <= divisor;
                    end
                end
                INITIALIZE: begin
                    q_reg <= abs_dvd;
                    m_reg <= {1'b0, abs_dvs};
                    a_reg <= '0;
                    count <= '0;
                    q_neg <= dvd_r[N-1] ^ dvs_r[N-1];
                    r_neg <= dvd_r[N-1];
                    if (dvs_r == '0) begin
                        quotient       <= '1;
                        remainder      <= dvd_r;
                        divide_by_zero <= 1'b1;
                    end else begin
                        divide_by_zero <= 1'b0;
                    end
                end
                SHIFT: begin
                    a_reg <= {a_reg[N-1:0], q_reg[N-1]};
                    q_reg <= {q_reg[N-2:0], 1'b0};
                end
                TEST: begin
                    // Negative difference means restore: keep A, quotient bit 0.
                    if (!sum[N]) begin
                        a_reg    <= sum;
                        q_reg[0] <= 1'b1;
                    end else begin
                        q_reg[0] <= 1'b0;
                    end
                    count <= count + 1'b1;
                end
                SIGN_FIX: begin
                    quotient  <= q_neg ? -q_reg : q_reg;
                    remainder <= r_neg ? -a_reg[N-1:0] : a_reg[N-1:0];
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule
